// File: rtl/gpio_seg7_display.sv
// Drives a 4-digit multiplexed seven-segment display from the 8-bit GPIO LED value.
// It shows the value in decimal, converted by a sequential double-dabble, or as two hex nibbles.
module gpio_seg7_display #(
   parameter int unsigned REFRESH_COUNTS = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] value_in,
   input  logic       hex_mode,
   output logic [6:0] seg_n,
   output logic [3:0] an_n,
   output logic       busy
);

   localparam int unsigned CW = $clog2(REFRESH_COUNTS);
   localparam logic [4:0] BLANK = 5'h10;

   typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

   state_t            state;
   logic [7:0]        shadow_value;
   logic              shadow_mode;
   logic [7:0]        bin;
   logic [11:0]       bcd;
   logic [11:0]       bcd_adj;
   logic [2:0]        shift_cnt;
   // Each digit is {blank, nibble}; glyph decoding happens at scan time.
   logic [3:0][4:0]   digits;
   logic [3:0][4:0]   next_digits;
   logic [CW-1:0]     refresh_cnt;
   logic [1:0]        scan_idx;

   function automatic logic [6:0] glyph(input logic [4:0] d);
      logic [6:0] g;
      if (d[4]) begin
         g = 7'h7F;
      end else begin
         case (d[3:0])
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
         endcase
      end
      return g;
   endfunction

   always_comb begin
      bcd_adj = bcd;
      for (int unsigned i = 0; i < 3; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   // Leading-zero blanking: tens only blank when hundreds are blank too.
   always_comb begin
      next_digits = {BLANK, BLANK, BLANK, BLANK};
      if (shadow_mode) begin
         next_digits[1] = {1'b0, shadow_value[7:4]};
         next_digits[0] = {1'b0, shadow_value[3:0]};
      end else begin
         next_digits[0] = {1'b0, bcd[3:0]};
         if (bcd[11:8] != 4'd0) next_digits[2] = {1'b0, bcd[11:8]};
         if (bcd[11:4] != 8'd0) next_digits[1] = {1'b0, bcd[7:4]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         shadow_value <= '0;
         shadow_mode  <= 1'b0;
         bin          <= '0;
         bcd          <= '0;
         shift_cnt    <= '0;
         busy         <= 1'b0;
         digits       <= {BLANK, BLANK, BLANK, 5'h00};
         refresh_cnt  <= '0;
         scan_idx     <= '0;
         seg_n        <= '1;
         an_n         <= '1;
      end else begin
         if (refresh_cnt == CW'(REFRESH_COUNTS - 1)) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 2'd1;
         end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
         end
         an_n  <= ~(4'b0001 << scan_idx);
         seg_n <= glyph(digits[scan_idx]);

         unique case (state)
            IDLE: begin
               if ({value_in, hex_mode} != {shadow_value, shadow_mode}) begin
                  shadow_value <= value_in;
                  shadow_mode  <= hex_mode;
                  bin          <= value_in;
                  bcd          <= '0;
                  shift_cnt    <= '0;
                  busy         <= 1'b1;
                  state        <= hex_mode ? LOAD : CONVERT;
               end
            end
            CONVERT: begin
               {bcd, bin} <= {bcd_adj, bin} << 1;
               shift_cnt  <= shift_cnt + 3'd1;
               if (shift_cnt == 3'd7) state <= LOAD;
            end
            LOAD: begin
               digits <= next_digits;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_seg7_display.sv
// Checks gpio_seg7_display against a cycle-level reference model of the display.
// The model computes the display contents from the displayed value with plain arithmetic.
module tb_gpio_seg7_display;

   localparam int unsigned R = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] value_in = 8'd0;
   logic       hex_mode = 1'b0;
   logic [6:0] seg_n;
   logic [3:0] an_n;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   gpio_seg7_display #(.REFRESH_COUNTS(R)) dut (
      .clk      (clk),
      .rst      (rst),
      .value_in (value_in),
      .hex_mode (hex_mode),
      .seg_n    (seg_n),
      .an_n     (an_n),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   logic [6:0] GLYPH [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   logic [3:0] AN_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   // Reference model state
   logic [6:0] m_disp [4];
   logic [6:0] m_pend [4];
   logic [7:0] m_sv;
   logic       m_sm;
   int         m_left, m_cnt, m_idx;
   logic [6:0] m_seg;
   logic [3:0] m_an;
   logic       m_busy;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic calc(input int v, input logic m);
      int h, t, u;
      for (int i = 0; i < 4; i++) m_pend[i] = 7'h7F;
      if (m) begin
         m_pend[0] = GLYPH[v % 16];
         m_pend[1] = GLYPH[v / 16];
      end else begin
         h = v / 100;
         t = (v / 10) % 10;
         u = v % 10;
         m_pend[0] = GLYPH[u];
         if (h != 0) m_pend[2] = GLYPH[h];
         if (h != 0 || t != 0) m_pend[1] = GLYPH[t];
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_sv = 8'd0; m_sm = 1'b0; m_left = 0; m_cnt = 0; m_idx = 0;
         m_seg = 7'h7F; m_an = 4'hF; m_busy = 1'b0;
         calc(0, 1'b0);
         for (int i = 0; i < 4; i++) m_disp[i] = m_pend[i];
      end else begin
         m_seg = m_disp[m_idx];
         m_an  = AN_PAT[m_idx];
         if (m_cnt == R - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 4;
         end else begin
            m_cnt++;
         end
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) for (int i = 0; i < 4; i++) m_disp[i] = m_pend[i];
         end else if (value_in != m_sv || hex_mode != m_sm) begin
            m_sv = value_in;
            m_sm = hex_mode;
            calc(int'(value_in), hex_mode);
            m_left = hex_mode ? 1 : 9;
         end
         m_busy = (m_left > 0);
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_edge();
         #1;
         chk("seg_n", {1'b0, seg_n}, {1'b0, m_seg});
         chk("an_n", {4'b0, an_n}, {4'b0, m_an});
         chk("busy", {7'b0, busy}, {7'b0, m_busy});
      end
   endtask

   initial begin
      step(3);
      chk("reset_seg", {1'b0, seg_n}, 8'h7F);
      chk("reset_an", {4'b0, an_n}, 8'h0F);
      chk("reset_busy", {7'b0, busy}, 8'h00);
      rst = 1'b0;
      step(1);
      chk("first_an", {4'b0, an_n}, 8'h0E);
      chk("first_seg", {1'b0, seg_n}, 8'h40);
      step(16);

      value_in = 8'd255;
      step(1);
      chk("busy_start_255", {7'b0, busy}, 8'h01);
      step(40);
      value_in = 8'd105;
      step(30);
      value_in = 8'd7;
      step(30);

      value_in = 8'hA5;
      hex_mode = 1'b1;
      step(1);
      chk("hex_busy", {7'b0, busy}, 8'h01);
      step(1);
      chk("hex_busy_end", {7'b0, busy}, 8'h00);
      step(20);

      hex_mode = 1'b0;
      value_in = 8'd200;
      step(3);
      value_in = 8'd99;
      step(30);

      value_in = 8'd123;
      step(4);
      rst = 1'b1;
      step(1);
      chk("midreset_seg", {1'b0, seg_n}, 8'h7F);
      chk("midreset_an", {4'b0, an_n}, 8'h0F);
      chk("midreset_busy", {7'b0, busy}, 8'h00);
      rst = 1'b0;
      step(30);

      for (int j = 0; j < 25; j++) begin
         value_in = 8'($urandom_range(0, 255));
         hex_mode = 1'($urandom_range(0, 1));
         step(int'($urandom_range(1, 24)));
      end
      step(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
